// File: rtl/cd_spi_bridge.sv
// SPI-slave (mode 0) front end that turns SPI frames into 8-bit CSR reads/writes
// for the CDBUS controller. All SPI pins are oversampled on clk.
module cd_spi_bridge (
  input  logic       clk,
  input  logic       reset,
  input  logic       nss,
  input  logic       sck,
  input  logic       sdi,
  output logic       sdo,
  output logic       sdo_en,
  output logic       chip_select,
  output logic [4:0] csr_address,
  output logic       csr_read,
  input  logic [7:0] csr_readdata,
  output logic       csr_write,
  output logic [7:0] csr_writedata
);

  localparam int unsigned DataW = 8;
  localparam int unsigned AddrW = 5;
  localparam int unsigned CntW  = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WR,
    ST_RD,
    ST_HOLD
  } state_e;

  // [1] is the synchronised level, [2] the edge-detect history flop
  logic [2:0] nss_sync_q;
  logic [2:0] sck_sync_q;
  logic [1:0] sdi_sync_q;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [DataW-2:0]   rx_q, rx_d;
  logic [DataW-1:0]   tx_q, tx_d;
  logic [AddrW-1:0]   addr_q, addr_d;
  logic [DataW-1:0]   wdata_q, wdata_d;
  logic               wr_q, wr_d;
  logic               rd_q, rd_d;
  logic               rd_pend_q, rd_pend_d;
  logic               skip_q, skip_d;
  logic               cs_q, cs_d;

  logic               nss_hi, nss_fall, nss_rise;
  logic               sck_rise, sck_fall;
  logic               byte_done;
  logic [DataW-1:0]   rx_byte;

  // Pin synchronisers carry no reset so they keep tracking the pins during reset
  always_ff @(posedge clk) begin
    nss_sync_q <= {nss_sync_q[1:0], nss};
    sck_sync_q <= {sck_sync_q[1:0], sck};
    sdi_sync_q <= {sdi_sync_q[0], sdi};
  end

  assign nss_hi    = nss_sync_q[1];
  assign nss_fall  = ~nss_sync_q[1] & nss_sync_q[2];
  assign nss_rise  = nss_sync_q[1] & ~nss_sync_q[2];
  assign sck_rise  = sck_sync_q[1] & ~sck_sync_q[2];
  assign sck_fall  = ~sck_sync_q[1] & sck_sync_q[2];
  assign rx_byte   = {rx_q, sdi_sync_q[1]};
  assign byte_done = sck_rise && (cnt_q == CntW'(7));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= nss_sync_q[1] ? ST_IDLE : ST_HOLD;
      cnt_q     <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      rd_pend_q <= 1'b0;
      skip_q    <= 1'b0;
      cs_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      rd_pend_q <= rd_pend_d;
      skip_q    <= skip_d;
      cs_q      <= cs_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wr_d      = 1'b0;
    rd_d      = 1'b0;
    rd_pend_d = rd_q;
    skip_d    = skip_q;
    cs_d      = cs_q;

    case (state_q)
      ST_IDLE: begin
        if (nss_fall) begin
          state_d = ST_CMD;
          cnt_d   = '0;
          rx_d    = '0;
          tx_d    = '0;
          skip_d  = 1'b0;
          cs_d    = 1'b1;
        end
      end

      ST_CMD, ST_WR, ST_RD: begin
        if (sck_rise) begin
          rx_d  = rx_byte[DataW-2:0];
          cnt_d = cnt_q + CntW'(1);
        end
        // The fall right after a byte boundary keeps the freshly loaded bit7
        if (sck_fall) begin
          if (skip_q) begin
            skip_d = 1'b0;
          end else begin
            tx_d = {tx_q[DataW-2:0], 1'b0};
          end
        end
        if (rd_pend_q && (state_q == ST_RD)) begin
          tx_d = csr_readdata;
        end
        if (byte_done) begin
          skip_d = 1'b1;
          if (state_q == ST_CMD) begin
            addr_d = rx_byte[AddrW-1:0];
            if (rx_byte[DataW-1]) begin
              state_d = ST_WR;
            end else begin
              state_d = ST_RD;
              rd_d    = 1'b1;
            end
          end else if (state_q == ST_WR) begin
            wr_d    = 1'b1;
            wdata_d = rx_byte;
          end else begin
            rd_d = 1'b1;
          end
        end
        // nss rise drops any partial byte and cancels a coincident strobe
        if (nss_rise) begin
          state_d = ST_IDLE;
          cs_d    = 1'b0;
          tx_d    = '0;
          wr_d    = 1'b0;
          rd_d    = 1'b0;
        end
      end

      ST_HOLD: begin
        if (nss_hi) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cs_d    = 1'b0;
      end
    endcase
  end

  assign sdo           = tx_q[DataW-1];
  assign sdo_en        = cs_q;
  assign chip_select   = cs_q;
  assign csr_address   = addr_q;
  assign csr_read      = rd_q;
  assign csr_write     = wr_q;
  assign csr_writedata = wdata_q;

endmodule

// File: tb/tb_cd_spi_bridge.sv
// Scoreboard bench for cd_spi_bridge: an SPI master drives directed frames, a CSR
// responder returns read data, and a monitor checks strobes and MISO bytes.
module tb_cd_spi_bridge;

  logic       clk = 1'b0;
  logic       reset;
  logic       nss;
  logic       sck;
  logic       sdi;
  logic       sdo;
  logic       sdo_en;
  logic       chip_select;
  logic [4:0] csr_address;
  logic       csr_read;
  logic [7:0] csr_readdata;
  logic       csr_write;
  logic [7:0] csr_writedata;

  typedef struct packed {
    logic       is_wr;
    logic [4:0] addr;
    logic [7:0] data;
  } txn_t;

  txn_t       exp_q[$];
  logic [7:0] exp_miso_q[$];
  logic [7:0] obs_miso_q[$];
  logic [7:0] resp_q[$];

  int checks = 0;
  int errors = 0;
  int half_p = 8;
  logic prev_wr = 1'b0;
  logic prev_rd = 1'b0;

  cd_spi_bridge dut (
    .clk          (clk),
    .reset        (reset),
    .nss          (nss),
    .sck          (sck),
    .sdi          (sdi),
    .sdo          (sdo),
    .sdo_en       (sdo_en),
    .chip_select  (chip_select),
    .csr_address  (csr_address),
    .csr_read     (csr_read),
    .csr_readdata (csr_readdata),
    .csr_write    (csr_write),
    .csr_writedata(csr_writedata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // CSR responder: data is valid the cycle after csr_read
  always @(posedge clk) begin
    if (csr_read) begin
      if (resp_q.size() > 0) csr_readdata <= resp_q.pop_front();
      else                   csr_readdata <= 8'hEE;
    end
  end

  // Monitor: pops expected strobes and MISO bytes as the DUT produces them
  always @(negedge clk) begin
    txn_t e;
    logic [7:0] em;
    logic [7:0] om;
    if (csr_write || csr_read) begin
      check("strobe_overlap", 32'(csr_write & csr_read), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: wr=%0b rd=%0b addr=0x%0h data=0x%0h, expected no strobe",
                 csr_write, csr_read, csr_address, csr_writedata);
      end else begin
        e = exp_q.pop_front();
        check("strobe_is_write", 32'(csr_write), 32'(e.is_wr));
        check("csr_address", 32'(csr_address), 32'(e.addr));
        if (e.is_wr) check("csr_writedata", 32'(csr_writedata), 32'(e.data));
      end
      if (csr_write) check("write_width", 32'(prev_wr), 32'd0);
      if (csr_read)  check("read_width", 32'(prev_rd), 32'd0);
    end
    prev_wr = csr_write;
    prev_rd = csr_read;
    if (obs_miso_q.size() > 0) begin
      om = obs_miso_q.pop_front();
      if (exp_miso_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL miso_unexpected: got 0x%0h expected none", om);
      end else begin
        em = exp_miso_q.pop_front();
        check("miso_byte", 32'(om), 32'(em));
      end
    end
  end

  initial begin
    repeat (40000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] mosi, input int nbits, output logic [7:0] miso);
    miso = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      sdi = mosi[i];
      wait_clk(half_p);
      miso[i] = sdo;
      sck = 1'b1;
      wait_clk(half_p);
      sck = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] mosi, input logic [7:0] exp_miso);
    logic [7:0] m;
    exp_miso_q.push_back(exp_miso);
    spi_bits(mosi, 8, m);
    obs_miso_q.push_back(m);
  endtask

  task automatic frame_end();
    wait_clk(half_p);
    nss = 1'b1;
    wait_clk(14);
  endtask

  task automatic push_wr(input logic [4:0] a, input logic [7:0] d);
    exp_q.push_back('{is_wr: 1'b1, addr: a, data: d});
  endtask

  task automatic push_rd(input logic [4:0] a);
    exp_q.push_back('{is_wr: 1'b0, addr: a, data: 8'h00});
  endtask

  task automatic drain_check(input string name);
    wait_clk(6);
    check({name, "_pending_strobes"}, 32'(exp_q.size()), 32'd0);
    check({name, "_pending_miso"}, 32'(exp_miso_q.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] m;
    logic [7:0] d;
    reset        = 1'b1;
    nss          = 1'b1;
    sck          = 1'b0;
    sdi          = 1'b0;
    csr_readdata = 8'h00;
    wait_clk(6);
    reset = 1'b0;
    wait_clk(2);
    check("rst_sdo", 32'(sdo), 32'd0);
    check("rst_sdo_en", 32'(sdo_en), 32'd0);
    check("rst_chip_select", 32'(chip_select), 32'd0);
    check("rst_csr_address", 32'(csr_address), 32'd0);
    check("rst_csr_writedata", 32'(csr_writedata), 32'd0);
    check("rst_strobes", 32'({csr_read, csr_write}), 32'd0);

    // Single write: 0x85 then 0x3C
    push_wr(5'd5, 8'h3C);
    nss = 1'b0;
    wait_clk(6);
    check("frame_chip_select", 32'(chip_select), 32'd1);
    check("frame_sdo_en", 32'(sdo_en), 32'd1);
    spi_byte(8'h85, 8'h00);
    spi_byte(8'h3C, 8'h00);
    frame_end();
    check("end_chip_select", 32'(chip_select), 32'd0);
    check("end_sdo_en", 32'(sdo_en), 32'd0);
    drain_check("write");

    // Write burst to 0x0A
    push_wr(5'h0A, 8'h11);
    push_wr(5'h0A, 8'h22);
    push_wr(5'h0A, 8'h33);
    nss = 1'b0;
    spi_byte(8'h8A, 8'h00);
    spi_byte(8'h11, 8'h00);
    spi_byte(8'h22, 8'h00);
    spi_byte(8'h33, 8'h00);
    frame_end();
    drain_check("burst");

    // Read from 0x02: three reads, MISO 00 A5 5A
    resp_q.push_back(8'hA5);
    resp_q.push_back(8'h5A);
    push_rd(5'd2);
    push_rd(5'd2);
    push_rd(5'd2);
    nss = 1'b0;
    spi_byte(8'h02, 8'h00);
    spi_byte(8'h00, 8'hA5);
    spi_byte(8'h00, 8'h5A);
    frame_end();
    drain_check("read");

    // Abort: partial data byte after 0x83 must not write
    nss = 1'b0;
    spi_byte(8'h83, 8'h00);
    spi_bits(8'hA0, 4, m);
    frame_end();
    push_wr(5'd4, 8'h77);
    nss = 1'b0;
    spi_byte(8'h84, 8'h00);
    spi_byte(8'h77, 8'h00);
    frame_end();
    drain_check("abort");

    // Reset during bit 3 of a data byte while nss stays low
    nss = 1'b0;
    spi_byte(8'h86, 8'h00);
    spi_bits(8'hF0, 3, m);
    reset = 1'b1;
    wait_clk(1);
    reset = 1'b0;
    wait_clk(2);
    check("midrst_chip_select", 32'(chip_select), 32'd0);
    check("midrst_sdo_en", 32'(sdo_en), 32'd0);
    check("midrst_csr_address", 32'(csr_address), 32'd0);
    check("midrst_csr_writedata", 32'(csr_writedata), 32'd0);
    check("midrst_sdo", 32'(sdo), 32'd0);
    spi_bits(8'h0F, 8, m);
    spi_bits(8'hFF, 8, m);
    check("hold_chip_select", 32'(chip_select), 32'd0);
    check("hold_sdo", 32'(sdo), 32'd0);
    frame_end();
    push_wr(5'd6, 8'h99);
    nss = 1'b0;
    spi_byte(8'h86, 8'h00);
    spi_byte(8'h99, 8'h00);
    frame_end();
    drain_check("midreset");

    // Minimum-margin 16-byte read burst from 0x1F
    half_p = 6;
    for (int i = 0; i < 16; i++) begin
      d = {4'(i), ~4'(i)};
      resp_q.push_back(d);
    end
    for (int i = 0; i < 17; i++) push_rd(5'h1F);
    nss = 1'b0;
    spi_byte(8'h1F, 8'h00);
    for (int i = 0; i < 16; i++) begin
      d = {4'(i), ~4'(i)};
      spi_byte(8'hFF, d);
    end
    frame_end();
    drain_check("margin");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
